// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared FSM state type and output buffer sizing for mem_burst_reader
package mem_burst_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  localparam int BUF_DEPTH = 2;
  localparam int PTRW = $clog2(BUF_DEPTH);
  localparam int OCCW = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/mem_burst_buf.sv
// mem_burst_buf: small FIFO of {last, data} words; push and pop may coincide even when full
module mem_burst_buf
  import mem_burst_pkg::*;
#(
  parameter int W = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic [OCCW-1:0] occ
);
  logic [W-1:0] ent [BUF_DEPTH];
  logic [PTRW-1:0] wp, rp;
  assign dout = ent[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '{default: '0};
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push) begin
        ent[wp] <= din;
        wp      <= wp + PTRW'(1);
      end
      if (pop) rp <= rp + PTRW'(1);
      occ <= occ + OCCW'(push) - OCCW'(pop);
    end
  end
endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: issues burst reads to a 1-cycle-latency sync memory and streams the words out
module mem_burst_reader
  import mem_burst_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 32,
  parameter int LENWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [LENWIDTH-1:0]  req_len,
  output logic [ADDRWIDTH-1:0] mem_addr,
  input  logic [DATAWIDTH-1:0] mem_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic                 busy
);
  state_t state;
  logic [LENWIDTH-1:0] issue_cnt, ret_cnt;
  logic in_flight, pop, issue, head_last;
  logic [OCCW-1:0] occ;
  logic [OCCW:0] use_cnt;
  assign pop       = rd_valid & rd_ready;
  assign use_cnt   = (OCCW+1)'(occ) - (OCCW+1)'(pop) + (OCCW+1)'(in_flight);
  // An issue means the memory is sampling mem_addr at this edge; its word lands in the buffer next edge.
  assign issue     = (state == BURST) && (use_cnt < (OCCW+1)'(BUF_DEPTH));
  assign rd_valid  = occ != '0;
  assign rd_last   = rd_valid & head_last;
  assign busy      = state != IDLE;
  assign req_ready = (state == IDLE) & ~rst;
  mem_burst_buf #(.W(DATAWIDTH + 1)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (in_flight),
    .pop  (pop),
    .din  ({ret_cnt == '0, mem_data}),
    .dout ({head_last, rd_data}),
    .occ  (occ)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (in_flight) ret_cnt <= ret_cnt - LENWIDTH'(1);
      if (issue) begin
        mem_addr  <= mem_addr + ADDRWIDTH'(1);
        issue_cnt <= issue_cnt - LENWIDTH'(1);
      end
      case (state)
        IDLE: if (req_valid) begin
          state     <= BURST;
          mem_addr  <= req_addr;
          issue_cnt <= req_len;
          ret_cnt   <= req_len;
        end
        BURST: if (issue && issue_cnt == '0) state <= DRAIN;
        DRAIN: if (pop && rd_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader: directed bursts against a preloaded memory model (mem[i] = i + 0x100)
module tb_mem_burst_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [11:0] req_addr = '0;
  logic [7:0] req_len = '0;
  logic [11:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic rd_valid;
  logic rd_ready = 1'b1;
  logic [31:0] rd_data;
  logic rd_last;
  logic busy;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] memory [4096];
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int cyc_q[$];
  logic prev_stall = 1'b0;
  logic [32:0] prev_word = '0;
  logic bp_done;
  logic [15:0] pat = 16'b1001_0110_1100_1001;

  mem_burst_reader dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .mem_addr(mem_addr), .mem_data(mem_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= memory[mem_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Samples between edges; a word seen valid&ready here transfers at the next rising edge.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(rd_valid), 64'd1);
        chk("stall_word", 64'({rd_last, rd_data}), 64'(prev_word));
      end
      if (rd_valid && rd_ready) begin
        got_q.push_back({rd_last, rd_data});
        cyc_q.push_back(cyc);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_word = {rd_last, rd_data};
    end
  end

  task automatic send_req(input logic [11:0] a, input logic [7:0] l);
    int i;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    req_len = l;
    for (i = 0; i < 1000 && !req_ready; i++) @(negedge clk);
    if (i == 1000) chk("req_timeout", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk("idle_timeout", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_burst(input logic [11:0] a, input int l);
    logic [11:0] ad;
    for (int i = 0; i <= l; i++) begin
      ad = a + 12'(i);
      exp_q.push_back({i == l, 32'(ad) + 32'h100});
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) memory[i] = i + 32'h100;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    send_req(12'h010, 8'd0);
    chk("single_busy", 64'(busy), 64'd1);
    wait_idle();
    expect_burst(12'h010, 0);
    check_all("single");

    send_req(12'h000, 8'd7);
    chk("stream_addr", 64'(mem_addr), 64'h000);
    chk("stream_lat1", 64'(rd_valid), 64'd0);
    @(negedge clk);
    chk("stream_lat2", 64'(rd_valid), 64'd0);
    @(negedge clk);
    chk("stream_lat3", 64'(rd_valid), 64'd1);
    wait_idle();
    chk("stream_span", 64'(cyc_q.size() == 8 ? cyc_q[7] - cyc_q[0] : -1), 64'd7);
    expect_burst(12'h000, 7);
    check_all("stream");

    bp_done = 1'b0;
    fork
      begin send_req(12'h200, 8'd15); wait_idle(); bp_done = 1'b1; end
      begin
        for (int i = 0; !bp_done && i < 3000; i++) begin
          @(negedge clk);
          rd_ready = pat[i % 16];
        end
        rd_ready = 1'b1;
      end
    join
    expect_burst(12'h200, 15);
    check_all("backpressure");

    send_req(12'hFFE, 8'd3);
    chk("wrap_addr", 64'(mem_addr), 64'hFFE);
    wait_idle();
    expect_burst(12'hFFE, 3);
    check_all("wrap");

    send_req(12'h300, 8'd31);
    for (int i = 0; i < 200 && got_q.size() < 5; i++) begin
      @(negedge clk);
      #3;
    end
    chk("mid_words", 64'(got_q.size()), 64'd5);
    rst = 1'b1;
    #1;
    chk("mid_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    cyc_q.delete();
    send_req(12'h020, 8'd1);
    wait_idle();
    repeat (4) @(negedge clk);
    expect_burst(12'h020, 1);
    check_all("after_rst");

    send_req(12'h040, 8'd3);
    req_valid = 1'b1;
    req_addr = 12'h080;
    req_len = 8'd2;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      chk("b2b_hold", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    chk("b2b_gap", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_busy", 64'(busy), 64'd1);
    wait_idle();
    expect_burst(12'h040, 3);
    expect_burst(12'h080, 2);
    check_all("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
